// File: rtl/sr_load_sequencer_if.sv
// Handshake and chain-drive bundle between the configuration requesters and
// the serial load sequencer.
interface sr_load_sequencer_if #(
   parameter int SIZESRSTAT  = 88,
   parameter int SIZESRDYN   = 16,
   parameter int SIZEADDRMUX = 7
);
   logic                   req_stat;
   logic [SIZESRSTAT-1:0]  data_stat;
   logic                   req_dyn;
   logic [SIZESRDYN-1:0]   data_dyn;
   logic                   abort;
   logic                   sel_stat;
   logic                   sel_dyn;
   logic                   sr_en;
   logic                   signal_out;
   logic                   en_fin;
   logic                   ack_stat;
   logic                   ack_dyn;
   logic                   busy;
   logic [SIZEADDRMUX-1:0] bit_idx;

   // Requester / configuration side.
   modport master (
      output req_stat, data_stat, req_dyn, data_dyn, abort,
      input  sel_stat, sel_dyn, sr_en, signal_out, en_fin,
             ack_stat, ack_dyn, busy, bit_idx
   );

   // Sequencer side.
   modport slave (
      input  req_stat, data_stat, req_dyn, data_dyn, abort,
      output sel_stat, sel_dyn, sr_en, signal_out, en_fin,
             ack_stat, ack_dyn, busy, bit_idx
   );
endinterface

// File: rtl/sr_load_sequencer.sv
// Shares one serial configuration chain between a static and a dynamic
// requester: arbitrate, serialize MSB-first, latch, acknowledge.
module sr_load_sequencer #(
   parameter int SIZESRSTAT  = 88,
   parameter int SIZESRDYN   = 16,
   parameter int SIZEADDRMUX = 7
) (
   input logic              CLK,
   input logic              RST,
   sr_load_sequencer_if.slave bus
);

   localparam int PAD_W = SIZESRSTAT - SIZESRDYN;
   localparam logic [SIZEADDRMUX-1:0] LAST_STAT = SIZEADDRMUX'(SIZESRSTAT - 1);
   localparam logic [SIZEADDRMUX-1:0] LAST_DYN  = SIZEADDRMUX'(SIZESRDYN - 1);

   if ((2 ** SIZEADDRMUX) < SIZESRSTAT) begin : g_bad_addr_width
      $error("SIZEADDRMUX too small to index SIZESRSTAT bits");
   end
   if (SIZESRDYN >= SIZESRSTAT) begin : g_bad_dyn_width
      $error("SIZESRDYN must be smaller than SIZESRSTAT");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                  state_r;
   logic                    grant_stat_r;      // 1: static owns the chain
   logic                    last_grant_stat_r; // 1: static was granted last
   logic [SIZESRSTAT-1:0]   shadow_r;          // bits still to be shifted, MSB-aligned
   logic [SIZEADDRMUX-1:0]  bit_idx_r;
   logic                    sel_stat_r;
   logic                    sel_dyn_r;
   logic                    sr_en_r;
   logic                    signal_out_r;
   logic                    en_fin_r;
   logic                    ack_stat_r;
   logic                    ack_dyn_r;
   logic                    busy_r;

   logic                    grant_valid_s;
   logic                    pick_stat_s;
   logic                    cancel_s;
   logic [SIZESRSTAT-1:0]   aligned_s;

   // Arbitration: abort blocks any grant, contention alternates.
   always_comb begin
      grant_valid_s = 1'b0;
      pick_stat_s   = 1'b0;
      if (bus.abort) begin
         grant_valid_s = 1'b0;
         pick_stat_s   = 1'b0;
      end else if (bus.req_stat && bus.req_dyn) begin
         grant_valid_s = 1'b1;
         pick_stat_s   = ~last_grant_stat_r;
      end else if (bus.req_stat) begin
         grant_valid_s = 1'b1;
         pick_stat_s   = 1'b1;
      end else if (bus.req_dyn) begin
         grant_valid_s = 1'b1;
         pick_stat_s   = 1'b0;
      end else begin
         grant_valid_s = 1'b0;
         pick_stat_s   = 1'b0;
      end
   end

   // Granted word, MSB-aligned so both chains shift out of the same bit.
   always_comb begin
      aligned_s = '0;
      if (grant_stat_r) begin
         aligned_s = bus.data_stat;
      end else begin
         aligned_s = {bus.data_dyn, {PAD_W{1'b0}}};
      end
   end

   // Abort only cancels while the chain is still being filled.
   always_comb begin
      cancel_s = 1'b0;
      if (bus.abort && ((state_r == LOAD) || (state_r == SHIFT))) begin
         cancel_s = 1'b1;
      end else begin
         cancel_s = 1'b0;
      end
   end

   // Sequencer FSM with all chain-side outputs registered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r           <= IDLE;
         grant_stat_r      <= 1'b0;
         last_grant_stat_r <= 1'b0;
         shadow_r          <= '0;
         bit_idx_r         <= '0;
         sel_stat_r        <= 1'b0;
         sel_dyn_r         <= 1'b0;
         sr_en_r           <= 1'b0;
         signal_out_r      <= 1'b0;
         en_fin_r          <= 1'b0;
         ack_stat_r        <= 1'b0;
         ack_dyn_r         <= 1'b0;
         busy_r            <= 1'b0;
      end else if (cancel_s) begin
         // last_grant is deliberately kept so the other side wins next time.
         state_r      <= IDLE;
         shadow_r     <= '0;
         bit_idx_r    <= '0;
         sel_stat_r   <= 1'b0;
         sel_dyn_r    <= 1'b0;
         sr_en_r      <= 1'b0;
         signal_out_r <= 1'b0;
         en_fin_r     <= 1'b0;
         ack_stat_r   <= 1'b0;
         ack_dyn_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ack_stat_r <= 1'b0;
               ack_dyn_r  <= 1'b0;
               if (grant_valid_s) begin
                  state_r           <= LOAD;
                  grant_stat_r      <= pick_stat_s;
                  last_grant_stat_r <= pick_stat_s;
                  sel_stat_r        <= pick_stat_s;
                  sel_dyn_r         <= ~pick_stat_s;
                  bit_idx_r         <= pick_stat_s ? LAST_STAT : LAST_DYN;
                  busy_r            <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  sel_stat_r <= 1'b0;
                  sel_dyn_r  <= 1'b0;
                  bit_idx_r  <= '0;
                  busy_r     <= 1'b0;
               end
            end
            LOAD: begin
               state_r      <= SHIFT;
               shadow_r     <= aligned_s << 1;
               signal_out_r <= aligned_s[SIZESRSTAT-1];
               sr_en_r      <= 1'b1;
            end
            SHIFT: begin
               if (bit_idx_r == '0) begin
                  state_r      <= LATCH;
                  shadow_r     <= '0;
                  sr_en_r      <= 1'b0;
                  signal_out_r <= 1'b0;
                  en_fin_r     <= 1'b1;
               end else begin
                  state_r      <= SHIFT;
                  shadow_r     <= shadow_r << 1;
                  signal_out_r <= shadow_r[SIZESRSTAT-1];
                  bit_idx_r    <= bit_idx_r - SIZEADDRMUX'(1);
               end
            end
            LATCH: begin
               state_r    <= DONE;
               en_fin_r   <= 1'b0;
               sel_stat_r <= 1'b0;
               sel_dyn_r  <= 1'b0;
               ack_stat_r <= grant_stat_r;
               ack_dyn_r  <= ~grant_stat_r;
            end
            DONE: begin
               state_r    <= IDLE;
               ack_stat_r <= 1'b0;
               ack_dyn_r  <= 1'b0;
               busy_r     <= 1'b0;
            end
            default: begin
               state_r      <= IDLE;
               shadow_r     <= '0;
               bit_idx_r    <= '0;
               sel_stat_r   <= 1'b0;
               sel_dyn_r    <= 1'b0;
               sr_en_r      <= 1'b0;
               signal_out_r <= 1'b0;
               en_fin_r     <= 1'b0;
               ack_stat_r   <= 1'b0;
               ack_dyn_r    <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel_stat   = sel_stat_r;
   assign bus.sel_dyn    = sel_dyn_r;
   assign bus.sr_en      = sr_en_r;
   assign bus.signal_out = signal_out_r;
   assign bus.en_fin     = en_fin_r;
   assign bus.ack_stat   = ack_stat_r;
   assign bus.ack_dyn    = ack_dyn_r;
   assign bus.busy       = busy_r;
   assign bus.bit_idx    = bit_idx_r;

endmodule

// File: doc/sr_load_sequencer.md
Name: sr_load_sequencer

Overview:
- Controller that shares the serial configuration chain between two requesters: static SR (SIZESRSTAT bits) and dynamic SR (SIZESRDYN bits).
- Accepts a parallel word from the granted requester, serializes it MSB-first onto the chain and drives the chain selects.
- Pulses en_fin to latch the chain, then acknowledges the requester.
- Sits between the configuration logic and the shift-register/address-mux datapath.

Parameters:
- SIZESRSTAT, 88, static shift-register length in bits.
- SIZESRDYN, 16, dynamic shift-register length in bits.
- SIZEADDRMUX, 7, bit counter width; must satisfy 2^SIZEADDRMUX >= SIZESRSTAT (elaboration-time check).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_stat  in  1  static load request, level; hold until ack_stat.
- data_stat  in  SIZESRSTAT  static word; sampled in LOAD only.
- req_dyn  in  1  dynamic load request, level; hold until ack_dyn.
- data_dyn  in  SIZESRDYN  dynamic word; sampled in LOAD only.
- abort  in  1  synchronous cancel of the transfer in progress.
- sel_stat  out  1  static chain selected.
- sel_dyn  out  1  dynamic chain selected.
- sr_en  out  1  chain shift enable.
- signal_out  out  1  serial data to the chain.
- en_fin  out  1  one-cycle latch pulse.
- ack_stat  out  1  one-cycle completion pulse for static.
- ack_dyn  out  1  one-cycle completion pulse for dynamic.
- busy  out  1  high in every state except IDLE.
- bit_idx  out  SIZEADDRMUX  current bit counter, drives the address mux.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. On RST:
  - state=IDLE.
  - All outputs 0; bit_idx=0.
  - Shadow register cleared.
  - last_grant=dyn, so static wins the first contention.
- All outputs are registered.
- States: IDLE -> LOAD -> SHIFT -> LATCH -> DONE -> IDLE.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, use round-robin: grant the opposite of last_grant, then update last_grant.
  - Go to LOAD on the next edge.
- LOAD (1 cycle):
  - Capture the granted word into the shadow register, MSB-aligned.
  - bit_idx = N-1, where N=SIZESRSTAT or SIZESRDYN.
  - Assert the granted sel_x; it stays high through LATCH.
- SHIFT (N cycles):
  - sr_en=1; signal_out = shadow MSB.
  - Each edge: shadow shifts left by 1 and bit_idx decrements.
  - When bit_idx==0, this is the last shift cycle; go to LATCH.
- LATCH (1 cycle): sr_en=0, signal_out=0, en_fin=1.
- DONE (1 cycle):
  - sel_x=0; ack for the granted requester=1.
  - Go to IDLE. A request still high in IDLE is treated as a new request.
- Latency: request sampled at edge k gives:
  - LOAD in cycle k+1.
  - First bit in cycle k+2, last bit in cycle k+1+N.
  - en_fin in cycle k+2+N; ack in cycle k+3+N.
  - Static total N+3=91 cycles; dynamic 19 cycles.
- Request dropped after grant: ignored; the transfer still completes and is acked.
- Data changing during SHIFT: ignored, because the shadow register is used.
- abort high in LOAD or SHIFT:
  - Next state IDLE; all outputs 0.
  - No en_fin, no ack; last_grant is kept.
- abort in LATCH or DONE: ignored.
- abort in IDLE: has priority over a new grant; no grant is made that cycle.
- sel_stat and sel_dyn are never high together; sel_x=0 whenever state is IDLE.
- RST mid-transfer: immediate return to reset values. No en_fin is issued, so the partially shifted chain is never latched.

Test Plan:
- Static load, data_stat=88'hA5...5A_0123: signal_out over 88 sr_en cycles equals data_stat MSB-first. en_fin appears 1 cycle after the last bit, ack_stat 1 cycle later, for 91 cycles total from the request edge.
- Dynamic load, data_dyn=16'hC3A1: 16 shift cycles with bits 1100001110100001, sel_dyn=1 and sel_stat=0 throughout, ack_dyn on cycle 19.
- req_stat and req_dyn both held from reset: grant order is stat, dyn, stat, dyn. Each request gets exactly one ack per transfer, with no overlap of sel signals.
- abort pulsed at shift bit 40 of a static transfer: busy falls the next cycle. No en_fin and no ack_stat. A pending req_dyn is granted next.
- RST asserted at shift bit 5 of a dynamic transfer: all outputs go to 0 asynchronously, before the next edge. After release, with req_dyn held, the dynamic transfer restarts from LOAD and completes normally.
- data_dyn toggled every cycle during SHIFT: the serialized output still matches the value captured in LOAD.
